sqrt_controller: RTL and testbench

Control FSM that sequences Data_Path through one integer square-root computation: load the operand, iterate the add/compare loop, then capture the result. It sits directly upstream of Data_Path, driving en_a/en_del/en_sq/en_out/ld_add and consuming greater. It exposes a level go/done handshake toward the top-level/switch logic, plus a saturation guard against runaway iteration.

---
 rtl/sqrt_controller.sv | 130 +++++++++++++
 tb/tb_sqrt_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt_controller
//  Description : Moore control FSM that sequences the square-root Data_Path
//                through load, an add/compare loop and result capture.
//                Provides a level go/done handshake, an iteration count and
//                a saturation flag for runs cut short by MAX_ITER.
//  Revision    : 1.0 - initial release
// ============================================================================
module sqrt_controller #(
    parameter int MAX_ITER = 15,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              go,
    input  logic              greater,
    output logic              en_a,
    output logic              en_del,
    output logic              en_sq,
    output logic              en_out,
    output logic              ld_add,
    output logic              busy,
    output logic              done,
    output logic              sat,
    output logic [ITER_W-1:0] iter
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] TEST = 3'd2;
    localparam logic [2:0] ADD  = 3'd3;
    localparam logic [2:0] OUT  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    logic [2:0] state;
    logic [2:0] next_state;

    // Whether the loop must stop on this TEST cycle for lack of convergence.
    logic at_limit;
    assign at_limit = (iter >= ITER_LIMIT);

    // Next-state logic; greater only matters in TEST and has priority over
    // the iteration limit.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (go) next_state = LOAD;
            LOAD: next_state = TEST;
            TEST: begin
                if (greater)       next_state = OUT;
                else if (at_limit) next_state = OUT;
                else               next_state = ADD;
            end
            ADD:  next_state = TEST;
            OUT:  next_state = DONE;
            DONE: if (!go) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register; clr forces IDLE immediately so every output drops.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= next_state;
    end

    // Iteration count and saturation flag: cleared when a run starts, held
    // through DONE and IDLE so the last run can be inspected afterwards.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            iter <= '0;
            sat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        iter <= '0;
                        sat  <= 1'b0;
                    end
                end
                TEST: begin
                    if (!greater && at_limit) sat <= 1'b1;
                end
                ADD: begin
                    // ADD is only reachable below the limit; the guard keeps
                    // the counter from wrapping regardless.
                    if (!at_limit) iter <= iter + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        en_a   = 1'b0;
        en_del = 1'b0;
        en_sq  = 1'b0;
        en_out = 1'b0;
        ld_add = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state)
            LOAD: begin
                en_a   = 1'b1;
                en_sq  = 1'b1;
                en_del = 1'b1;
                busy   = 1'b1;
            end
            TEST: busy = 1'b1;
            ADD: begin
                en_sq  = 1'b1;
                en_del = 1'b1;
                ld_add = 1'b1;
                busy   = 1'b1;
            end
            OUT: begin
                en_out = 1'b1;
                busy   = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sqrt_controller
//  Description : Scoreboard bench for sqrt_controller with a behavioural
//                Data_Path model closing the greater loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sqrt_controller;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       go  = 1'b0;
    logic       greater;
    logic       en_a, en_del, en_sq, en_out, ld_add, busy, done, sat;
    logic [3:0] iter;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural Data_Path
    logic [7:0]  a_in  = 8'd0;
    logic [7:0]  a_q   = 8'd0;
    logic [15:0] sq_q  = 16'd0;
    logic [15:0] del_q = 16'd0;
    logic [15:0] out_q = 16'd0;
    int          gmode = 0;   // 0 = real compare, 1 = stuck 0, 2 = stuck 1

    typedef struct {
        int iter;
        int sat;
        int sqrt;
        int done_cyc;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int a;
        int mode;
        int k;
        int s;
        int r;
    } vec_t;

    sqrt_controller #(.MAX_ITER(15), .ITER_W(4)) dut (
        .clk     (clk),
        .clr     (clr),
        .go      (go),
        .greater (greater),
        .en_a    (en_a),
        .en_del  (en_del),
        .en_sq   (en_sq),
        .en_out  (en_out),
        .ld_add  (ld_add),
        .busy    (busy),
        .done    (done),
        .sat     (sat),
        .iter    (iter)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign greater = (gmode == 1) ? 1'b0 :
                     (gmode == 2) ? 1'b1 : (sq_q > {8'd0, a_q});

    always @(posedge clk) begin
        if (en_a) a_q <= a_in;
        if (en_sq)  sq_q  <= ld_add ? sq_q + del_q : 16'd1;
        if (en_del) del_q <= ld_add ? del_q + 16'd2 : 16'd3;
        if (en_out) out_q <= (del_q >> 1) - 16'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle control legality plus scoreboard pop on done rise.
    logic [6:0] vec;
    logic       prev_done = 1'b0;
    int         adds = 0;
    int         outs = 0;
    always @(negedge clk) begin
        if (clr) begin
            prev_done = 1'b0;
            adds = 0;
            outs = 0;
        end else begin
            vec = {en_a, en_del, en_sq, en_out, ld_add, busy, done};
            total++;
            if (!(vec inside {7'b0000000, 7'b1110010, 7'b0000010,
                              7'b0110110, 7'b0001010, 7'b0000001})) begin
                bad++;
                $display("FAIL ctrl_pattern: got %b not a legal state decode (t=%0t)", vec, $time);
            end
            if (en_a)   begin adds = 0; outs = 0; end
            if (ld_add) adds++;
            if (en_out) outs++;
            if (done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: got done=1 expected no pending run (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("iter",     int'(iter),  e.iter);
                    chk("sat",      int'(sat),   e.sat);
                    chk("sqrt",     int'(out_q), e.sqrt);
                    chk("done_cyc", cyc,         e.done_cyc);
                    chk("add_cnt",  adds,        e.iter);
                    chk("out_cnt",  outs,        1);
                end
            end
            prev_done = done;
        end
    end

    task automatic start_run(input vec_t v);
        @(negedge clk);
        #1;
        a_in  = 8'(v.a);
        gmode = v.mode;
        go    = 1'b1;
        exp_q.push_back('{v.k, v.s, v.r, cyc + 1 + 2 * v.k + 3});
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got done=0 expected 1 within 100 cycles");
        end
    endtask

    task automatic finish_run(input int hold);
        wait_done();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("done_hold", int'(done), 1);
        end
        #1;
        go = 1'b0;
        @(negedge clk);
        chk("done_drop", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    vec_t runs[8] = '{
        '{10,  0, 3,  0, 3},
        '{0,   0, 0,  0, 0},
        '{1,   0, 1,  0, 1},
        '{15,  0, 3,  0, 3},
        '{16,  0, 4,  0, 4},
        '{200, 0, 14, 0, 14},
        '{255, 0, 15, 0, 15},
        '{10,  0, 3,  0, 3}
    };

    initial begin
        // Reset state while clr is held
        repeat (2) @(negedge clk);
        chk("rst_ctrl", int'({en_a, en_del, en_sq, en_out, ld_add, busy, done}), 0);
        chk("rst_iter", int'(iter), 0);
        chk("rst_sat",  int'(sat),  0);
        #1;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_go", int'(busy), 0);

        // clr mid-ADD of an a=10 run
        start_run(runs[0]);
        begin
            int n = 0;
            while (!ld_add && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("reach_add", int'(ld_add), 1);
        end
        #1;
        clr = 1'b1;
        go  = 1'b0;
        #1;
        chk("clr_ctrl", int'({en_a, en_del, en_sq, en_out, ld_add, busy, done}), 0);
        chk("clr_iter", int'(iter), 0);
        exp_q.delete();
        @(negedge clk);
        #1;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_clr_idle", int'({busy, done, en_out}), 0);

        // Nominal directed runs
        for (int i = 0; i < 8; i++) begin
            start_run(runs[i]);
            finish_run(0);
        end

        // go held high through DONE must not retrigger
        start_run(runs[0]);
        finish_run(10);

        // Saturation with greater stuck low, then immediate exit with it stuck high
        start_run('{0, 1, 15, 1, 15});
        finish_run(0);
        start_run('{0, 2, 0, 0, 0});
        finish_run(0);
        gmode = 0;

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
